// File: rtl/issue_queue.sv
// ---------------------------------------------------------------------------
// issue_queue
//   Circular instruction buffer between fetch/decode and issue. Up to two
//   entries are pushed per cycle at the tail. The head and head+1 entries are
//   presented combinationally on two issue slots. Slot 2 is granted only when
//   the pair is independent, or when it is the delay slot of a jump in slot 1.
//
// Ports
//   clk, rst           clock; reset is asynchronous and active-low
//   flush              drop every buffered entry (wins over push and pop)
//   stall              downstream stall, nothing issues while high
//   in_valid_1/2       push requests (slot 2 only counts together with slot 1)
//   in_data_1/2        {pc[31:0], inst[31:0]}
//   in_meta_1/2        predecode {jmp, ls, hilo, w_ena, w_dst[4:0]}
//   in_ready           at least two free entries (based on registered count)
//   out_valid_1/2      entry issued on slot 1 / slot 2 this cycle
//   out_data_1/2       head / head+1 entry data
//   out_meta_1/2       head / head+1 entry predecode
//   out_delay_slot_2   slot 2 carries the delay slot of the slot 1 jump
//   out_adel_1/2       misaligned pc (pc[1:0] != 0) of the slot entry
//   count              current occupancy
//   cnt_single/dual    cycles with exactly one / two issues (saturating)
//   cnt_full           cycles with in_ready low (saturating)
// ---------------------------------------------------------------------------
module issue_queue #(
  parameter int DEPTH   = 8,
  parameter int DUAL_EN = 1,
  parameter int HOLD_DS = 1,
  parameter int CNT_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       stall,
  input  logic                       in_valid_1,
  input  logic                       in_valid_2,
  input  logic [63:0]                in_data_1,
  input  logic [63:0]                in_data_2,
  input  logic [8:0]                 in_meta_1,
  input  logic [8:0]                 in_meta_2,
  output logic                       in_ready,
  output logic                       out_valid_1,
  output logic                       out_valid_2,
  output logic [63:0]                out_data_1,
  output logic [63:0]                out_data_2,
  output logic [8:0]                 out_meta_1,
  output logic [8:0]                 out_meta_2,
  output logic                       out_delay_slot_2,
  output logic                       out_adel_1,
  output logic                       out_adel_2,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [CNT_W-1:0]           cnt_single,
  output logic [CNT_W-1:0]           cnt_dual,
  output logic [CNT_W-1:0]           cnt_full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int ENT_W = 73;  // {meta[8:0], pc[31:0], inst[31:0]}

  // Predecode field positions inside the 9-bit meta word
  localparam int M_JMP  = 8;
  localparam int M_LS   = 7;
  localparam int M_HILO = 6;
  localparam int M_WENA = 5;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [OCC_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] cnt_single_q, cnt_single_d;
  logic [CNT_W-1:0] cnt_dual_q, cnt_dual_d;
  logic [CNT_W-1:0] cnt_full_q, cnt_full_d;

  // Entry storage; contents are never reset, validity comes from count_q
  logic [ENT_W-1:0] mem_q [DEPTH];

  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;
  logic [ENT_W-1:0] ent_1;
  logic [ENT_W-1:0] ent_2;
  logic [8:0]       meta_1;
  logic [8:0]       meta_2;
  logic [4:0]       rs_2;
  logic [4:0]       rt_2;
  logic             ready;
  logic             push_en;
  logic             push_two;
  logic [1:0]       push_num;
  logic [1:0]       pop_num;
  logic             hold;
  logic             raw;
  logic             pair_ok;
  logic             issue_1;
  logic             issue_2;

  // -------------------------------------------------------------------------
  // Issue / push decisions
  // -------------------------------------------------------------------------
  always_comb begin
    head_p1 = head_q + PTR_W'(1);
    tail_p1 = tail_q + PTR_W'(1);
    ent_1   = mem_q[head_q];
    ent_2   = mem_q[head_p1];
    meta_1  = ent_1[72:64];
    meta_2  = ent_2[72:64];
    rs_2    = ent_2[25:21];
    rt_2    = ent_2[20:16];

    // Readiness ignores same-cycle pops so it stays a clean flop-driven signal
    ready    = (count_q <= OCC_W'(DEPTH - 2));
    push_en  = ready & in_valid_1 & ~flush;
    push_two = push_en & in_valid_2;
    push_num = {1'b0, push_en} + {1'b0, push_two};

    // A lone jump at the head waits until its delay slot is buffered
    hold = (HOLD_DS != 0) & meta_1[M_JMP] & (count_q == OCC_W'(1));

    raw = meta_1[M_WENA] &
          (((meta_1[4:0] == rs_2) & (rs_2 != 5'd0)) |
           ((meta_1[4:0] == rt_2) & (rt_2 != 5'd0)));

    // A jump always pairs with its delay slot; otherwise slot 2 must be free
    // of hazards with slot 1 and must not itself be a jump.
    if (meta_1[M_JMP]) begin
      pair_ok = 1'b1;
    end else begin
      pair_ok = ~(raw | meta_1[M_LS] | meta_2[M_JMP] | meta_1[M_HILO]);
    end

    issue_1 = (count_q != '0) & ~stall & ~flush & ~hold;
    issue_2 = issue_1 & (DUAL_EN != 0) & (count_q >= OCC_W'(2)) & pair_ok;
    pop_num = {1'b0, issue_1} + {1'b0, issue_2};
  end

  // -------------------------------------------------------------------------
  // Next-state for pointers, occupancy and performance counters
  // -------------------------------------------------------------------------
  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    cnt_single_d = cnt_single_q;
    cnt_dual_d   = cnt_dual_q;
    cnt_full_d   = cnt_full_q;

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + PTR_W'(pop_num);
      tail_d  = tail_q + PTR_W'(push_num);
      count_d = count_q + OCC_W'(push_num) - OCC_W'(pop_num);
    end

    // Counters keep running through flush; they saturate instead of wrapping
    if (issue_1 & ~issue_2 & (cnt_single_q != {CNT_W{1'b1}})) begin
      cnt_single_d = cnt_single_q + CNT_W'(1);
    end
    if (issue_2 & (cnt_dual_q != {CNT_W{1'b1}})) begin
      cnt_dual_d = cnt_dual_q + CNT_W'(1);
    end
    if (~ready & (cnt_full_q != {CNT_W{1'b1}})) begin
      cnt_full_d = cnt_full_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      cnt_single_q <= '0;
      cnt_dual_q   <= '0;
      cnt_full_q   <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      cnt_single_q <= cnt_single_d;
      cnt_dual_q   <= cnt_dual_d;
      cnt_full_q   <= cnt_full_d;
    end
  end

  // Storage write port: slot 1 lands at the tail, slot 2 right behind it
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[tail_q] <= {in_meta_1, in_data_1};
    end
    if (push_two) begin
      mem_q[tail_p1] <= {in_meta_2, in_data_2};
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign in_ready         = ready;
  assign out_valid_1      = issue_1;
  assign out_valid_2      = issue_2;
  assign out_data_1       = ent_1[63:0];
  assign out_data_2       = ent_2[63:0];
  assign out_meta_1       = meta_1;
  assign out_meta_2       = meta_2;
  assign out_delay_slot_2 = issue_2 & meta_1[M_JMP];
  assign out_adel_1       = (ent_1[33:32] != 2'b00);
  assign out_adel_2       = (ent_2[33:32] != 2'b00);
  assign count            = count_q;
  assign cnt_single       = cnt_single_q;
  assign cnt_dual         = cnt_dual_q;
  assign cnt_full         = cnt_full_q;

endmodule
